// File: rtl/eth_rst_pkg.sv
// Shared definitions for the 10G Ethernet reset sequencer: sequencer state
// encoding and the counter width helper.
package eth_rst_pkg;

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_LINK    = 2'd2,
    ST_RUN     = 2'd3
  } seq_state_e;

  localparam int RETRY_W = 8;

  // Bits needed by a counter that runs 0 .. terminal-1 (never fewer than one).
  function automatic int cnt_w(input int terminal);
    return (terminal < 2) ? 1 : $clog2(terminal);
  endfunction

endpackage

// File: rtl/eth_port_rst.sv
// Per-port reset bundle: global assert, staggered release, timed soft re-reset
// and the registered port_ready flag.
module eth_port_rst
  import eth_rst_pkg::*;
#(
  parameter int RST_WIDTH = 8,
  parameter int SOFT_HOLD = 64
) (
  input  logic                 clk156,
  input  logic                 sys_rst,
  input  logic                 glob_assert,
  input  logic                 rel_stb,
  input  logic                 soft_req,
  input  logic                 link_up,
  output logic [RST_WIDTH-1:0] bundle,
  output logic                 released,
  output logic                 port_ready
);

  localparam int SC_W = cnt_w(SOFT_HOLD);

  logic            bundle_q,   bundle_d;
  logic            soft_act_q, soft_act_d;
  logic [SC_W-1:0] soft_cnt_q, soft_cnt_d;
  logic            ready_q,    ready_d;

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    bundle_d   = bundle_q;
    soft_act_d = soft_act_q;
    soft_cnt_d = soft_cnt_q;

    // A global retry overrides everything, including a pending soft count.
    if (glob_assert) begin
      bundle_d   = 1'b1;
      soft_act_d = 1'b0;
      soft_cnt_d = '0;
    end else if (soft_req) begin
      bundle_d   = 1'b1;
      soft_act_d = 1'b1;
      soft_cnt_d = '0;
    end else if (soft_act_q) begin
      if (soft_cnt_q == SC_W'(SOFT_HOLD - 1)) begin
        bundle_d   = 1'b0;
        soft_act_d = 1'b0;
        soft_cnt_d = '0;
      end else begin
        soft_cnt_d = soft_cnt_q + SC_W'(1);
      end
    end else if (rel_stb) begin
      bundle_d = 1'b0;
    end

    // Follows the bundle's next value so ready drops on the same edge the bundle asserts.
    ready_d = !bundle_d && link_up;
  end

  // NOTE: state registers use non-blocking assignments only; the async reset lands
  // on the safe value (bundle asserted) without waiting for a clock.
  always_ff @(posedge clk156 or posedge sys_rst) begin
    if (sys_rst) begin
      bundle_q   <= 1'b1;
      soft_act_q <= 1'b0;
      soft_cnt_q <= '0;
      ready_q    <= 1'b0;
    end else begin
      bundle_q   <= bundle_d;
      soft_act_q <= soft_act_d;
      soft_cnt_q <= soft_cnt_d;
      ready_q    <= ready_d;
    end
  end

  assign bundle     = {RST_WIDTH{bundle_q}};
  assign released   = !bundle_q;
  assign port_ready = ready_q;

endmodule

// File: rtl/eth_rst_seq.sv
// Reset sequencer for the clk156 Ethernet ports: cold hold, staggered per-port
// release, link wait with timeout-driven global retry, and per-port soft reset.
module eth_rst_seq
  import eth_rst_pkg::*;
#(
  parameter int NUM_PORTS      = 2,
  parameter int RST_WIDTH      = 8,
  parameter int HOLD_CYCLES    = 16383,
  parameter int STAGGER_CYCLES = 16,
  parameter int LINK_TIMEOUT   = 1000000,
  parameter int SOFT_HOLD      = 64
) (
  input  logic                           clk156,
  input  logic                           sys_rst,
  input  logic                           init_mem,
  input  logic [NUM_PORTS-1:0]           link_up,
  input  logic [NUM_PORTS-1:0]           port_rst_req,
  output logic [NUM_PORTS*RST_WIDTH-1:0] eth_rst,
  output logic [NUM_PORTS-1:0]           port_ready,
  output logic                           all_ready,
  output logic [1:0]                     seq_state,
  output logic [RETRY_W-1:0]             retry_cnt
);

  localparam int HOLD_W = cnt_w(HOLD_CYCLES);
  localparam int STG_W  = cnt_w(STAGGER_CYCLES);
  localparam int LNK_W  = cnt_w(LINK_TIMEOUT);
  localparam int IDX_W  = cnt_w(NUM_PORTS);

  seq_state_e         state_q,   state_d;
  logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic [STG_W-1:0]   stg_cnt_q,  stg_cnt_d;
  logic [LNK_W-1:0]   link_cnt_q, link_cnt_d;
  logic [IDX_W-1:0]   idx_q,      idx_d;
  logic [RETRY_W-1:0] retry_q,    retry_d;

  logic                 glob_assert;
  logic                 rel_fire;
  logic [NUM_PORTS-1:0] rel_stb;
  logic [NUM_PORTS-1:0] soft_vec;
  logic [NUM_PORTS-1:0] released;
  logic                 all_ok;
  logic                 timeout_hit;

  always_comb begin
    // Soft requests only count once every port has been through its cold release.
    soft_vec    = ((state_q == ST_LINK) || (state_q == ST_RUN)) ? port_rst_req : '0;
    all_ok      = (&(released & link_up)) && (soft_vec == '0);
    timeout_hit = (LINK_TIMEOUT != 0) && (link_cnt_q == LNK_W'(LINK_TIMEOUT - 1));

    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    stg_cnt_d   = stg_cnt_q;
    link_cnt_d  = link_cnt_q;
    idx_d       = idx_q;
    retry_d     = retry_q;
    glob_assert = 1'b0;
    rel_fire    = 1'b0;

    unique case (state_q)
      ST_HOLD: begin
        if (init_mem) begin
          if (hold_cnt_q == HOLD_W'(HOLD_CYCLES - 1)) begin
            state_d    = ST_RELEASE;
            hold_cnt_d = '0;
            stg_cnt_d  = '0;
            idx_d      = '0;
          end else begin
            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
          end
        end
      end

      ST_RELEASE: begin
        if (stg_cnt_q == STG_W'(STAGGER_CYCLES - 1)) begin
          rel_fire  = 1'b1;
          stg_cnt_d = '0;
          if (idx_q == IDX_W'(NUM_PORTS - 1)) begin
            state_d    = ST_LINK;
            idx_d      = '0;
            link_cnt_d = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          stg_cnt_d = stg_cnt_q + STG_W'(1);
        end
      end

      ST_LINK: begin
        // Link-up on the timeout cycle still counts as success.
        if (all_ok) begin
          state_d    = ST_RUN;
          link_cnt_d = '0;
        end else if (timeout_hit) begin
          glob_assert = 1'b1;
          state_d     = ST_HOLD;
          hold_cnt_d  = '0;
          link_cnt_d  = '0;
          if (retry_q != {RETRY_W{1'b1}}) retry_d = retry_q + RETRY_W'(1);
        end else if (LINK_TIMEOUT != 0) begin
          link_cnt_d = link_cnt_q + LNK_W'(1);
        end
      end

      ST_RUN: begin
        if (soft_vec != '0) begin
          state_d    = ST_LINK;
          link_cnt_d = '0;
        end
      end

      default: state_d = ST_HOLD;
    endcase

    for (int p = 0; p < NUM_PORTS; p++) begin
      rel_stb[p] = rel_fire && (idx_q == IDX_W'(p));
    end
  end

  always_ff @(posedge clk156 or posedge sys_rst) begin
    if (sys_rst) begin
      state_q    <= ST_HOLD;
      hold_cnt_q <= '0;
      stg_cnt_q  <= '0;
      link_cnt_q <= '0;
      idx_q      <= '0;
      retry_q    <= '0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      stg_cnt_q  <= stg_cnt_d;
      link_cnt_q <= link_cnt_d;
      idx_q      <= idx_d;
      retry_q    <= retry_d;
    end
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    eth_port_rst #(
      .RST_WIDTH (RST_WIDTH),
      .SOFT_HOLD (SOFT_HOLD)
    ) u_port (
      .clk156      (clk156),
      .sys_rst     (sys_rst),
      .glob_assert (glob_assert),
      .rel_stb     (rel_stb[p]),
      .soft_req    (soft_vec[p]),
      .link_up     (link_up[p]),
      .bundle      (eth_rst[p*RST_WIDTH +: RST_WIDTH]),
      .released    (released[p]),
      .port_ready  (port_ready[p])
    );
  end

  assign seq_state = state_q;
  assign all_ready = (state_q == ST_RUN);
  assign retry_cnt = retry_q;

endmodule

// File: tb/tb_eth_rst_seq.sv
// Self-checking bench for eth_rst_seq: expectations are queued per edge number
// (edges counted from reset release) and compared on the following falling edge.
module tb_eth_rst_seq;

  localparam int NP = 2;
  localparam int RW = 8;

  logic             clk156 = 1'b0;
  logic             sys_rst;
  logic             init_mem;
  logic [NP-1:0]    link_up;
  logic [NP-1:0]    port_rst_req;
  logic [NP*RW-1:0] eth_rst;
  logic [NP-1:0]    port_ready;
  logic             all_ready;
  logic [1:0]       seq_state;
  logic [7:0]       retry_cnt;

  eth_rst_seq #(
    .NUM_PORTS      (NP),
    .RST_WIDTH      (RW),
    .HOLD_CYCLES    (10),
    .STAGGER_CYCLES (4),
    .LINK_TIMEOUT   (20),
    .SOFT_HOLD      (6)
  ) dut (
    .clk156       (clk156),
    .sys_rst      (sys_rst),
    .init_mem     (init_mem),
    .link_up      (link_up),
    .port_rst_req (port_rst_req),
    .eth_rst      (eth_rst),
    .port_ready   (port_ready),
    .all_ready    (all_ready),
    .seq_state    (seq_state),
    .retry_cnt    (retry_cnt)
  );

  always #5 clk156 = ~clk156;

  int edge_cnt;
  always @(posedge clk156 or posedge sys_rst) begin
    if (sys_rst) edge_cnt <= 0;
    else         edge_cnt <= edge_cnt + 1;
  end

  typedef enum {SIG_ETH, SIG_READY, SIG_ALL, SIG_STATE, SIG_RETRY} sig_e;
  typedef struct {
    int          cyc;
    sig_e        sig;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  function automatic logic [31:0] observe(input sig_e s);
    case (s)
      SIG_ETH:   return {16'd0, eth_rst};
      SIG_READY: return {30'd0, port_ready};
      SIG_ALL:   return {31'd0, all_ready};
      SIG_STATE: return {30'd0, seq_state};
      default:   return {24'd0, retry_cnt};
    endcase
  endfunction

  task automatic do_reset();
    port_rst_req = '0;
    sys_rst = 1'b1;
    @(negedge clk156);
    @(negedge clk156);
    sys_rst = 1'b0;
  endtask

  task automatic test_reset();
    init_mem = 1'b1; link_up = 2'b11; port_rst_req = '0;
    sys_rst = 1'b1;
    #1;
    checks++; if (eth_rst !== 16'hffff) begin errors++; $display("FAIL reset eth_rst: got %h want ffff", eth_rst); end
    checks++; if (port_ready !== 2'b00) begin errors++; $display("FAIL reset port_ready: got %b want 00", port_ready); end
    checks++; if (seq_state !== 2'd0) begin errors++; $display("FAIL reset seq_state: got %0d want 0", seq_state); end
    checks++; if (retry_cnt !== 8'd0) begin errors++; $display("FAIL reset retry_cnt: got %0d want 0", retry_cnt); end
    checks++; if (all_ready !== 1'b0) begin errors++; $display("FAIL reset all_ready: got %b want 0", all_ready); end
    repeat (3) @(negedge clk156);
    checks++; if (eth_rst !== 16'hffff) begin errors++; $display("FAIL reset held eth_rst: got %h want ffff", eth_rst); end
  endtask

  task automatic test_cold_release();
    logic [31:0] obs;
    sb.delete();
    init_mem = 1'b1; link_up = 2'b11;
    sb.push_back('{9,  SIG_STATE, 32'd0});
    sb.push_back('{10, SIG_STATE, 32'd1});
    sb.push_back('{13, SIG_ETH,   32'hffff});
    sb.push_back('{14, SIG_ETH,   32'hff00});
    sb.push_back('{14, SIG_READY, 32'd1});
    sb.push_back('{17, SIG_ETH,   32'hff00});
    sb.push_back('{18, SIG_ETH,   32'h0000});
    sb.push_back('{18, SIG_STATE, 32'd2});
    sb.push_back('{19, SIG_STATE, 32'd3});
    sb.push_back('{19, SIG_READY, 32'd3});
    sb.push_back('{19, SIG_ALL,   32'd1});
    sb.push_back('{22, SIG_ALL,   32'd1});
    do_reset();
    for (int c = 0; c < 23; c++) begin
      @(negedge clk156);
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].cyc == edge_cnt) begin
          obs = observe(sb[i].sig);
          checks++;
          if (obs !== sb[i].val) begin
            errors++;
            $display("FAIL cold %s edge %0d: got %0h want %0h", sb[i].sig.name(), edge_cnt, obs, sb[i].val);
          end
          sb.delete(i);
        end
      end
    end
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL cold pending: got %0d unchecked want 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_init_gate();
    logic [31:0] obs;
    sb.delete();
    init_mem = 1'b1; link_up = 2'b11;
    sb.push_back('{14, SIG_STATE, 32'd0});
    sb.push_back('{15, SIG_STATE, 32'd1});
    sb.push_back('{18, SIG_ETH,   32'hffff});
    sb.push_back('{19, SIG_ETH,   32'hff00});
    sb.push_back('{22, SIG_ETH,   32'hff00});
    sb.push_back('{23, SIG_ETH,   32'h0000});
    sb.push_back('{24, SIG_STATE, 32'd3});
    do_reset();
    for (int c = 0; c < 27; c++) begin
      @(negedge clk156);
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].cyc == edge_cnt) begin
          obs = observe(sb[i].sig);
          checks++;
          if (obs !== sb[i].val) begin
            errors++;
            $display("FAIL init_gate %s edge %0d: got %0h want %0h", sb[i].sig.name(), edge_cnt, obs, sb[i].val);
          end
          sb.delete(i);
        end
      end
      if (edge_cnt == 3) init_mem = 1'b0;
      if (edge_cnt == 8) init_mem = 1'b1;
    end
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL init_gate pending: got %0d unchecked want 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_timeout();
    logic [31:0] obs;
    sb.delete();
    init_mem = 1'b1; link_up = 2'b01;
    sb.push_back('{37,    SIG_STATE, 32'd2});
    sb.push_back('{37,    SIG_ETH,   32'h0000});
    sb.push_back('{37,    SIG_RETRY, 32'd0});
    sb.push_back('{38,    SIG_STATE, 32'd0});
    sb.push_back('{38,    SIG_ETH,   32'hffff});
    sb.push_back('{38,    SIG_RETRY, 32'd1});
    sb.push_back('{38,    SIG_READY, 32'd0});
    sb.push_back('{52,    SIG_ETH,   32'hff00});
    sb.push_back('{76,    SIG_RETRY, 32'd2});
    sb.push_back('{9689,  SIG_RETRY, 32'd254});
    sb.push_back('{9690,  SIG_RETRY, 32'd255});
    sb.push_back('{11400, SIG_RETRY, 32'd255});
    sb.push_back('{11400, SIG_STATE, 32'd0});
    do_reset();
    for (int c = 0; c < 11402; c++) begin
      @(negedge clk156);
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].cyc == edge_cnt) begin
          obs = observe(sb[i].sig);
          checks++;
          if (obs !== sb[i].val) begin
            errors++;
            $display("FAIL timeout %s edge %0d: got %0h want %0h", sb[i].sig.name(), edge_cnt, obs, sb[i].val);
          end
          sb.delete(i);
        end
      end
    end
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL timeout pending: got %0d unchecked want 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_soft_reset();
    logic [31:0] obs;
    sb.delete();
    init_mem = 1'b1; link_up = 2'b11;
    for (int e = 20; e <= 40; e++) begin
      sb.push_back('{e, SIG_ETH,   (e >= 25 && e <= 30) ? 32'hff00 : 32'h0000});
      sb.push_back('{e, SIG_READY, (e >= 25 && e <= 34) ? 32'd1 : 32'd3});
      sb.push_back('{e, SIG_STATE, (e >= 25 && e <= 34) ? 32'd2 : 32'd3});
    end
    do_reset();
    for (int c = 0; c < 42; c++) begin
      @(negedge clk156);
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].cyc == edge_cnt) begin
          obs = observe(sb[i].sig);
          checks++;
          if (obs !== sb[i].val) begin
            errors++;
            $display("FAIL soft %s edge %0d: got %0h want %0h", sb[i].sig.name(), edge_cnt, obs, sb[i].val);
          end
          sb.delete(i);
        end
      end
      if (edge_cnt == 24) begin port_rst_req = 2'b10; link_up = 2'b01; end
      if (edge_cnt == 25) port_rst_req = 2'b00;
      if (edge_cnt == 34) link_up = 2'b11;
    end
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL soft pending: got %0d unchecked want 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_reset_mid_release();
    logic [31:0] obs;
    sb.delete();
    init_mem = 1'b1; link_up = 2'b01;
    sb.push_back('{38, SIG_RETRY, 32'd1});
    sb.push_back('{52, SIG_ETH,   32'hff00});
    sb.push_back('{53, SIG_STATE, 32'd1});
    sb.push_back('{53, SIG_READY, 32'd1});
    do_reset();
    for (int c = 0; c < 53; c++) begin
      @(negedge clk156);
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].cyc == edge_cnt) begin
          obs = observe(sb[i].sig);
          checks++;
          if (obs !== sb[i].val) begin
            errors++;
            $display("FAIL mid_rst %s edge %0d: got %0h want %0h", sb[i].sig.name(), edge_cnt, obs, sb[i].val);
          end
          sb.delete(i);
        end
      end
    end
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL mid_rst pending: got %0d unchecked want 0", sb.size()); sb.delete(); end
    #2 sys_rst = 1'b1;
    #1;
    checks++; if (eth_rst !== 16'hffff) begin errors++; $display("FAIL mid_rst async eth_rst: got %h want ffff", eth_rst); end
    checks++; if (seq_state !== 2'd0) begin errors++; $display("FAIL mid_rst async seq_state: got %0d want 0", seq_state); end
    checks++; if (retry_cnt !== 8'd0) begin errors++; $display("FAIL mid_rst async retry_cnt: got %0d want 0", retry_cnt); end
    checks++; if (port_ready !== 2'b00) begin errors++; $display("FAIL mid_rst async port_ready: got %b want 00", port_ready); end
    @(negedge clk156);
    sys_rst = 1'b0;
  endtask

  task automatic test_link_timeout_race();
    logic [31:0] obs;
    sb.delete();
    init_mem = 1'b1; link_up = 2'b01;
    sb.push_back('{37, SIG_STATE, 32'd2});
    sb.push_back('{38, SIG_STATE, 32'd3});
    sb.push_back('{38, SIG_RETRY, 32'd0});
    sb.push_back('{38, SIG_ETH,   32'h0000});
    sb.push_back('{38, SIG_ALL,   32'd1});
    sb.push_back('{60, SIG_STATE, 32'd3});
    sb.push_back('{60, SIG_READY, 32'd3});
    do_reset();
    for (int c = 0; c < 62; c++) begin
      @(negedge clk156);
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].cyc == edge_cnt) begin
          obs = observe(sb[i].sig);
          checks++;
          if (obs !== sb[i].val) begin
            errors++;
            $display("FAIL race %s edge %0d: got %0h want %0h", sb[i].sig.name(), edge_cnt, obs, sb[i].val);
          end
          sb.delete(i);
        end
      end
      if (edge_cnt == 37) link_up = 2'b11;
    end
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL race pending: got %0d unchecked want 0", sb.size()); sb.delete(); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_cold_release();
    test_init_gate();
    test_timeout();
    test_soft_reset();
    test_reset_mid_release();
    test_link_timeout_race();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/eth_rst_seq.md
Name: eth_rst_seq

Overview:
- Parametrised reset sequencer for the 10G Ethernet subsystem in the clk156 domain. Generalises the single cold-reset counter to NUM_PORTS MAC/PCS ports.
- Holds all per-port reset bundles during cold init, then releases them port by port with a stagger, and waits for link-up with a timeout and global retry.
- Supports per-port soft re-reset at runtime.
- Sits between board-level init (init_mem) and the MAC/PCS/encap reset inputs.

Parameters:
- NUM_PORTS, 2, number of Ethernet ports (≥1).
- RST_WIDTH, 8, reset bits per port bundle; all bits of a bundle switch together.
- HOLD_CYCLES, 16383, cold-hold length in init_mem-qualified cycles (≥1).
- STAGGER_CYCLES, 16, cycles between successive port releases (≥1).
- LINK_TIMEOUT, 1000000, cycles allowed in LINK before global retry; 0 disables the timeout.
- SOFT_HOLD, 64, soft-reset assertion length per port (≥1).

Ports:
- clk156  in  1  datapath clock.
- sys_rst  in  1  asynchronous, active-high reset.
- init_mem  in  1  qualifies the cold-hold count.
- link_up  in  NUM_PORTS  per-port PCS block lock; synchronous to clk156.
- port_rst_req  in  NUM_PORTS  per-port soft-reset request pulse.
- eth_rst  out  NUM_PORTS*RST_WIDTH  active-high reset bundles; port p occupies bits [p*RST_WIDTH +: RST_WIDTH].
- port_ready  out  NUM_PORTS  port released and link up (registered).
- all_ready  out  1  high iff seq_state==RUN.
- seq_state  out  2  HOLD=0, RELEASE=1, LINK=2, RUN=3.
- retry_cnt  out  8  saturating count of link-timeout retries.

Behaviour:
- Reset values (sys_rst=1, takes effect asynchronously, immediately): eth_rst all ones, port_ready 0, seq_state HOLD, retry_cnt 0, all internal counters 0. Reset applies equally mid-operation.
- HOLD:
  - All bundles asserted, port_ready 0.
  - hold_cnt increments only on cycles with init_mem=1 and holds otherwise.
  - When hold_cnt==HOLD_CYCLES-1 with init_mem=1: go to RELEASE with port index 0 and stagger_cnt 0.
- RELEASE:
  - stagger_cnt increments every cycle.
  - When it equals STAGGER_CYCLES-1: clear bundle[idx], reset stagger_cnt, increment idx.
  - After the last port is released, go to LINK with link_cnt 0.
  - With init_mem held high from reset release, port p's bundle deasserts on edge HOLD_CYCLES+(p+1)*STAGGER_CYCLES.
- port_ready[p] is registered: 1 when bundle p is released, no soft reset is active on p, and link_up[p]=1.
- LINK:
  - link_cnt increments every cycle.
  - If every port is released with link_up=1: go to RUN. This has priority over the timeout on the same cycle.
  - Otherwise, if LINK_TIMEOUT≠0 and link_cnt==LINK_TIMEOUT-1: global retry. All bundles reassert, retry_cnt increments (saturating at 255), return to HOLD with hold_cnt 0.
- RUN:
  - Link loss clears port_ready[p] the next cycle; there is no automatic re-reset.
  - all_ready stays high while in RUN.
- Soft reset (LINK or RUN only; ignored in HOLD/RELEASE):
  - port_rst_req[p] asserts bundle p the next edge for SOFT_HOLD cycles, clears port_ready[p], then releases bundle p.
  - A request during an active soft reset restarts that port's count.
  - In RUN, a soft request moves the state to LINK with link_cnt 0.
  - Other ports are unaffected.
- Simultaneous timeout and soft request: the timeout (global retry) wins; the pending soft count is cleared.
- Counter widths are $clog2 of their terminal value (minimum 1). No counter wraps: every counter is cleared on its terminal transition.

Decomposition:
- Package eth_rst_pkg: seq_state encoding localparams (ST_HOLD, ST_RELEASE, ST_LINK, ST_RUN) and a width helper function.
- Sub-module eth_port_rst, one instance per port (generate):
  - Holds the bundle register, SOFT_HOLD counter and port_ready register.
  - Inputs: global assert, release strobe, soft request.
- Top level holds the FSM, hold/stagger/link counters and retry_cnt.

Test Plan:
- NUM_PORTS=2, HOLD=10, STAGGER=4, init_mem=1, link_up=2'b11 -> bundle0 clears at edge 14, bundle1 at edge 18, port_ready=2'b11 and seq_state=3 after edge 19, all_ready=1.
- Same config, init_mem low for 5 cycles during HOLD -> both releases delayed exactly 5 edges (19, 23).
- LINK_TIMEOUT=20, link_up=2'b01 -> 20 cycles after entering LINK, all bundles reassert, retry_cnt=1, seq_state=0, and the sequence repeats; force 300 retries -> retry_cnt=255.
- In RUN, pulse port_rst_req=2'b10 with SOFT_HOLD=6 -> bundle1 high for 6 cycles, port_ready[1]=0, seq_state 2, then 3 once link_up[1]=1; bundle0 and port_ready[0] constant.
- Assert sys_rst mid-RELEASE after bundle0 cleared -> eth_rst all ones immediately (before the next edge), seq_state=0, retry_cnt=0.
- In LINK, final link_up rises on the same cycle link_cnt hits LINK_TIMEOUT-1 -> RUN, retry_cnt unchanged.
